match_record_writer: RTL and testbench
======================================

Name: match_record_writer

Overview:
- Drains match records produced by the comparator stage from the match FIFO.
- Writes each record into a circular buffer in external memory through an Avalon-MM write master.
- Tracks the ring write pointer and occupancy, and applies back-pressure from waitrequest.
- Drops whole records when the host has not freed space, and flags the overflow.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of ring slot 0.
- DEPTH, 256, number of record slots in the ring (power of two, ≥2).
- REC_WORDS, 4, 32-bit words per record (match flags, timestamp, src IP, dst IP).
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- enable  in  1  permits starting a new record.
- fifo_empty  in  1  match FIFO empty.
- fifo_rdata  in  32  match FIFO read data, valid the cycle after fifo_rdreq (non-show-ahead).
- fifo_rdreq  out  1  match FIFO read strobe, one cycle per word.
- avm_address  out  32  byte address.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_waitrequest  in  1  slave stall.
- host_release  in  1  single-cycle pulse: host consumed one record slot.
- wr_slot  out  $clog2(DEPTH)  next slot to be written.
- rec_count  out  CNT_W  occupied slots.
- overflow  out  1  sticky: at least one record dropped since reset.
- drop_count  out  16  dropped records, saturating at 16'hFFFF.
- rec_done  out  1  one-cycle pulse when a record is committed to memory.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: every output 0, state IDLE, word_idx 0. A reset mid-record abandons the record; avm_write is low the cycle after rst is sampled.
- States: IDLE, FETCH, LATCH, WRITE, DROP_FETCH, DROP_LATCH.
- IDLE:
  - If enable && !fifo_empty && rec_count<DEPTH: go FETCH.
  - If enable && !fifo_empty && rec_count==DEPTH: go DROP_FETCH.
  - word_idx is cleared on entry.
- FETCH:
  - fifo_rdreq=1 (combinational) only while !fifo_empty; go LATCH in the same cycle the strobe issues.
  - While the FIFO is empty, stay in FETCH.
- LATCH:
  - Register fifo_rdata into avm_writedata.
  - Register avm_address = BASE_ADDR + ((wr_slot*REC_WORDS + word_idx) << 2).
  - Set avm_write=1; go WRITE.
- WRITE:
  - Hold avm_address, avm_writedata and avm_write stable while avm_waitrequest=1.
  - On the cycle avm_waitrequest=0 the word is accepted: avm_write drops the next cycle.
  - If word_idx==REC_WORDS-1: commit and go IDLE.
  - Otherwise: word_idx++ and go FETCH.
- Commit:
  - rec_done pulses.
  - wr_slot++, wrapping DEPTH-1 to 0.
  - rec_count++.
- Minimum of 3 cycles per word; record latency is 3*REC_WORDS cycles with no stalls and FIFO data present.
- DROP_FETCH / DROP_LATCH:
  - Same FIFO sequencing as FETCH / LATCH, but data is discarded and no bus write occurs.
  - After REC_WORDS words: overflow<=1, drop_count++ (saturating), go IDLE.
  - wr_slot and rec_count are unchanged.
- enable deasserted mid-record: the current record (write or drop) completes; enable is sampled only in IDLE.
- host_release:
  - Decrements rec_count when rec_count>0; ignored when rec_count==0.
  - Simultaneous commit and host_release: rec_count unchanged.
  - With rec_count==DEPTH, a release in the same cycle IDLE evaluates is not seen; the full/drop decision uses the registered rec_count.
- FIFO underrun mid-record: wait in FETCH/DROP_FETCH indefinitely; there is no timeout.
- rec_count never exceeds DEPTH: commits happen only from the non-full path.

Decomposition:
- sniffer_pkg holds:
  - the mrw_state_t enum (4-bit logic);
  - the MATCH_REC_WORDS constant (=4);
  - the record word-index constants (WORD_FLAGS=0, WORD_TS=1, WORD_SRC=2, WORD_DST=3).
- One sub-module, match_ring_tracker, owns wr_slot wrap, the rec_count up/down with simultaneous-event rule, and full/empty flags. Inputs: clk, rst, commit, release. Outputs: wr_slot, rec_count, full.
- FSM, address generation and drop counter stay in match_record_writer.

Test Plan:
- Single record, no stalls:
  - Stimulus: FIFO holds A0..A3, waitrequest=0, BASE_ADDR=0.
  - Response: writes to 0x0, 0x4, 0x8, 0xC with A0..A3; rec_done on the 12th cycle after leaving IDLE; wr_slot=1, rec_count=1.
- Back-pressure:
  - Stimulus: waitrequest high 5 cycles on word 2.
  - Response: address 0x8 and data held stable all 5 cycles; exactly 4 accepted writes; latency 17 cycles.
- Wrap-around:
  - Stimulus: DEPTH=4; write 4 records with a host_release after each commit, then a 5th record.
  - Response: 5th record writes at 0x0..0xC; wr_slot=1; rec_count=1.
- Full/drop:
  - Stimulus: DEPTH=4; write 4 records with no release, then push 2 more records.
  - Response: 8 FIFO reads and 0 bus writes; overflow=1; drop_count=2; rec_count=4; wr_slot=0.
- Simultaneous commit and release:
  - Stimulus: rec_count=2; host_release asserted on the commit cycle.
  - Response: rec_count stays 2; release at rec_count=0 leaves it at 0.
- Reset mid-record:
  - Stimulus: assert rst for 1 cycle while in WRITE with waitrequest=1.
  - Response: next cycle avm_write=0, state IDLE, wr_slot=0, rec_count=0, overflow=0.

Source files
------------

// File: rtl/sniffer_pkg.sv
// sniffer_pkg: writer FSM state encoding and match record word layout
package sniffer_pkg;
    typedef enum logic [3:0] {IDLE, FETCH, LATCH, WRITE, DROP_FETCH, DROP_LATCH} mrw_state_t;
    localparam int MATCH_REC_WORDS = 4;
    localparam int WORD_FLAGS = 0;
    localparam int WORD_TS = 1;
    localparam int WORD_SRC = 2;
    localparam int WORD_DST = 3;
endpackage

// File: rtl/match_ring_tracker.sv
// match_ring_tracker: ring write slot (commit advances, wraps) and occupancy (commit up, host release down, both cancel) with full flag
module match_ring_tracker #(
    parameter int DEPTH = 256,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit,
    input  logic                     release_slot,
    output logic [$clog2(DEPTH)-1:0] wr_slot,
    output logic [CNT_W-1:0]         rec_count,
    output logic                     full
);
    localparam int SW = $clog2(DEPTH);
    logic dec;
    assign dec = release_slot && rec_count != '0;
    assign full = rec_count == CNT_W'(DEPTH);
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_slot <= '0;
            rec_count <= '0;
        end else begin
            if (commit) wr_slot <= wr_slot + SW'(1);
            rec_count <= (commit && !dec) ? rec_count + CNT_W'(1) :
                         (dec && !commit) ? rec_count - CNT_W'(1) : rec_count;
        end
    end
endmodule

// File: rtl/match_record_writer.sv
// match_record_writer: drains match FIFO records into an external memory ring over Avalon-MM, dropping whole records when the ring is full
module match_record_writer
    import sniffer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int DEPTH = 256,
    parameter int REC_WORDS = MATCH_REC_WORDS,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     fifo_empty,
    input  logic [31:0]              fifo_rdata,
    output logic                     fifo_rdreq,
    output logic [31:0]              avm_address,
    output logic                     avm_write,
    output logic [31:0]              avm_writedata,
    input  logic                     avm_waitrequest,
    input  logic                     host_release,
    output logic [$clog2(DEPTH)-1:0] wr_slot,
    output logic [CNT_W-1:0]         rec_count,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic                     rec_done,
    output logic                     busy
);
    localparam int WI_W = REC_WORDS > 1 ? $clog2(REC_WORDS) : 1;
    mrw_state_t state;
    logic [WI_W-1:0] word_idx;
    logic last, commit, full;
    assign last = word_idx == WI_W'(REC_WORDS - 1);
    assign commit = state == WRITE && !avm_waitrequest && last;
    assign fifo_rdreq = (state == FETCH || state == DROP_FETCH) && !fifo_empty;
    assign busy = state != IDLE;
    match_ring_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_tracker (
        .clk(clk),
        .rst(rst),
        .commit(commit),
        .release_slot(host_release),
        .wr_slot(wr_slot),
        .rec_count(rec_count),
        .full(full)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            word_idx <= '0;
            avm_address <= '0;
            avm_writedata <= '0;
            avm_write <= 1'b0;
            overflow <= 1'b0;
            drop_count <= '0;
            rec_done <= 1'b0;
        end else begin
            rec_done <= commit;
            case (state)
                IDLE: begin
                    word_idx <= '0;
                    if (enable && !fifo_empty) state <= full ? DROP_FETCH : FETCH;
                end
                FETCH: if (!fifo_empty) state <= LATCH;
                LATCH: begin
                    avm_writedata <= fifo_rdata;
                    avm_address <= BASE_ADDR + ((32'(wr_slot) * 32'(REC_WORDS) + 32'(word_idx)) << 2);
                    avm_write <= 1'b1;
                    state <= WRITE;
                end
                WRITE: if (!avm_waitrequest) begin
                    avm_write <= 1'b0;
                    state <= last ? IDLE : FETCH;
                    if (!last) word_idx <= word_idx + WI_W'(1);
                end
                DROP_FETCH: if (!fifo_empty) state <= DROP_LATCH;
                DROP_LATCH: begin
                    state <= last ? IDLE : DROP_FETCH;
                    if (!last) word_idx <= word_idx + WI_W'(1);
                    if (last) overflow <= 1'b1;
                    if (last) drop_count <= drop_count + {15'd0, drop_count != 16'hFFFF};
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_match_record_writer.sv
// tb_match_record_writer: table-driven record sequences with a write scoreboard and FIFO/slave responders
module tb_match_record_writer;
    localparam int DEPTH = 4;
    typedef struct {
        logic [31:0] seed;
        int stall;
        bit rel;
        int lat;
        int slot;
        int cnt;
        int drops;
        int wr;
    } row_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1, enable = 1'b0, fifo_empty = 1'b1, avm_waitrequest = 1'b0, host_release = 1'b0;
    logic [31:0] fifo_rdata = '0;
    logic fifo_rdreq, avm_write, overflow, rec_done, busy;
    logic [31:0] avm_address, avm_writedata;
    logic [1:0] wr_slot;
    logic [2:0] rec_count;
    logic [15:0] drop_count;
    match_record_writer #(.BASE_ADDR(32'h0), .DEPTH(DEPTH), .REC_WORDS(4)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_rdreq(fifo_rdreq),
        .avm_address(avm_address),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .host_release(host_release),
        .wr_slot(wr_slot),
        .rec_count(rec_count),
        .overflow(overflow),
        .drop_count(drop_count),
        .rec_done(rec_done),
        .busy(busy)
    );
    int ncmp = 0, nerr = 0;
    logic [31:0] fq[$];
    logic [63:0] exp_q[$];
    int nwrites = 0, nreads = 0, busy_cyc = 0, stall_left = 0, m_slot = 0, m_cnt = 0;
    bit saw_done = 0, obs_busy = 0, rel_on_commit = 0, prev_stall = 0;
    logic [31:0] prev_addr = '0, prev_data = '0;
    row_t rows[10];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask
    task automatic cycle();
        logic pop;
        logic [63:0] e;
        @(negedge clk);
        if (avm_write && prev_stall) begin
            chk("hold_addr", avm_address, prev_addr);
            chk("hold_data", avm_writedata, prev_data);
        end
        prev_stall = avm_write && avm_waitrequest;
        prev_addr = avm_address;
        prev_data = avm_writedata;
        if (avm_write && !avm_waitrequest) begin
            nwrites++;
            if (exp_q.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_write: got addr 0x%0h expected no write", avm_address);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", avm_address, e[63:32]);
                chk("wr_data", avm_writedata, e[31:0]);
            end
        end
        if (fifo_rdreq) nreads++;
        if (busy) busy_cyc++;
        obs_busy = busy;
        saw_done = rec_done;
        pop = fifo_rdreq;
        @(posedge clk);
        #1;
        if (pop && fq.size() != 0) fifo_rdata = fq.pop_front();
        fifo_empty = (fq.size() == 0);
        avm_waitrequest = avm_write && (nwrites % 4 == 2) && stall_left > 0;
        if (avm_waitrequest) stall_left--;
        host_release = rel_on_commit && avm_write && !avm_waitrequest && (nwrites % 4 == 3);
        if (host_release) rel_on_commit = 0;
    endtask
    task automatic rel();
        host_release = 1'b1;
        cycle();
        if (m_cnt > 0) m_cnt--;
    endtask
    task automatic run_rec(input logic [31:0] seed, input int stall, input bit drop_en);
        bit seen = 0;
        int n = 0;
        stall_left = stall;
        busy_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            fq.push_back(seed + 32'(i));
            if (m_cnt < DEPTH) exp_q.push_back({32'((m_slot * 4 + i) * 4), seed + 32'(i)});
        end
        if (m_cnt < DEPTH) begin
            m_slot = (m_slot + 1) % DEPTH;
            m_cnt++;
        end
        fifo_empty = 1'b0;
        enable = 1'b1;
        while (n < 200) begin
            cycle();
            n++;
            if (obs_busy) seen = 1;
            if (seen && drop_en) enable = 1'b0;
            if (seen && !obs_busy) break;
        end
        if (n >= 200) begin
            ncmp++;
            nerr++;
            $display("FAIL rec_timeout: got %0d cycles expected record completion", n);
        end
        enable = 1'b1;
    endtask
    initial begin
        int r0, w0, n;
        rows[0] = '{32'hA000_0000, 0, 1'b1, 12, 1, 0, 0, 4};
        rows[1] = '{32'hB000_0000, 5, 1'b1, 17, 2, 0, 0, 4};
        rows[2] = '{32'hC000_0000, 0, 1'b1, 12, 3, 0, 0, 4};
        rows[3] = '{32'hD000_0000, 0, 1'b1, 12, 0, 0, 0, 4};
        rows[4] = '{32'hE000_0000, 0, 1'b0, 12, 1, 1, 0, 4};
        rows[5] = '{32'hE100_0000, 0, 1'b0, 12, 2, 2, 0, 4};
        rows[6] = '{32'hE200_0000, 0, 1'b0, 12, 3, 3, 0, 4};
        rows[7] = '{32'hE300_0000, 0, 1'b0, 12, 0, 4, 0, 4};
        rows[8] = '{32'hF000_0000, 0, 1'b0, 8, 0, 4, 1, 0};
        rows[9] = '{32'hF100_0000, 0, 1'b0, 8, 0, 4, 2, 0};
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_write", avm_write, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_data", avm_writedata, 0);
        chk("rst_rdreq", fifo_rdreq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_slot", wr_slot, 0);
        chk("rst_count", rec_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drops", drop_count, 0);
        chk("rst_done", rec_done, 0);
        for (int i = 0; i < 10; i++) begin
            r0 = nreads;
            w0 = nwrites;
            run_rec(rows[i].seed, rows[i].stall, 1'b0);
            chk($sformatf("row%0d_latency", i), busy_cyc, rows[i].lat);
            chk($sformatf("row%0d_rec_done", i), saw_done, rows[i].wr != 0);
            chk($sformatf("row%0d_reads", i), nreads - r0, 4);
            chk($sformatf("row%0d_writes", i), nwrites - w0, rows[i].wr);
            if (rows[i].rel) rel();
            chk($sformatf("row%0d_slot", i), wr_slot, rows[i].slot);
            chk($sformatf("row%0d_count", i), rec_count, rows[i].cnt);
            chk($sformatf("row%0d_drops", i), drop_count, rows[i].drops);
        end
        chk("overflow_set", overflow, 1);
        rel();
        rel();
        chk("count_after_2_rel", rec_count, 2);
        rel_on_commit = 1;
        run_rec(32'h5500_0000, 0, 1'b1);
        chk("sim_rel_fired", rel_on_commit, 0);
        chk("sim_rel_done", saw_done, 1);
        chk("sim_rel_count", rec_count, 2);
        chk("sim_rel_slot", wr_slot, 1);
        rel();
        rel();
        rel();
        chk("rel_at_zero", rec_count, 0);
        chk("sb_drained", exp_q.size(), 0);
        stall_left = 50;
        for (int i = 0; i < 4; i++) begin
            fq.push_back(32'h7700_0000 + 32'(i));
            exp_q.push_back({32'((1 * 4 + i) * 4), 32'h7700_0000 + 32'(i)});
        end
        fifo_empty = 1'b0;
        n = 0;
        while (n < 60 && !(avm_write && avm_waitrequest)) begin
            cycle();
            n++;
        end
        chk("reach_stall", avm_write && avm_waitrequest, 1);
        rst = 1'b1;
        fq.delete();
        fifo_empty = 1'b1;
        enable = 1'b0;
        cycle();
        rst = 1'b0;
        stall_left = 0;
        exp_q.delete();
        chk("midrst_write", avm_write, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_slot", wr_slot, 0);
        chk("midrst_count", rec_count, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_drops", drop_count, 0);
        cycle();
        chk("midrst_idle", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
